// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit words, word 0 is a read-only ID.
// Optional per-register write strobe output enabled by AXI_LITE_REGS_WR_PULSE_EN.
module axi4_lite_slave_regs #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hBED0_0001
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              s_awaddr,
  input  logic [3:0]               s_awcache,
  input  logic [2:0]               s_awprot,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  output logic [1:0]               s_bresp,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  input  logic [31:0]              s_araddr,
  input  logic [3:0]               s_arcache,
  input  logic [2:0]               s_arprot,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int          IDX_W       = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN        = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  function automatic logic addr_hit(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (addr >= ADDR_BASE) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return off[IDX_W+1:2];
  endfunction

  wstate_t     wstate_q, wstate_d;
  rstate_t     rstate_q, rstate_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] reg_word [NUM_REGS];

  logic             aw_hs, w_hs, have_aw, have_w, wr_commit, wr_ok;
  logic [31:0]      cm_addr, cm_data;
  logic [3:0]       cm_strb;
  logic [IDX_W-1:0] wr_idx, ar_idx;
  logic             ar_hit;

  logic unused_sideband;
  assign unused_sideband = ^{s_awcache, s_awprot, s_arcache, s_arprot};

  // Word 0 is the constant ID; its storage slot is never written.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_words
      if (gi == 0) begin : g_id
        assign reg_word[gi] = ID_VALUE;
      end else begin : g_rw
        assign reg_word[gi] = regs_q[gi];
      end
      assign regs_out[gi*32 +: 32] = reg_word[gi];
    end
  endgenerate

  // A channel that handshakes this cycle is used directly, so AW+W together commit at once.
  always_comb begin
    aw_hs     = s_awvalid && awready_q;
    w_hs      = s_wvalid && wready_q;
    have_aw   = aw_held_q || aw_hs;
    have_w    = w_held_q || w_hs;
    cm_addr   = aw_held_q ? awaddr_q : s_awaddr;
    cm_data   = w_held_q ? wdata_q : s_wdata;
    cm_strb   = w_held_q ? wstrb_q : s_wstrb;
    wr_commit = (wstate_q != W_RESP) && have_aw && have_w;
    wr_idx    = addr_idx(cm_addr);
    wr_ok     = addr_hit(cm_addr) && (wr_idx != '0);
  end

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (wstate_q)
      W_IDLE, W_WAIT: begin
        if (aw_hs) begin
          awaddr_d  = s_awaddr;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
          w_held_d = 1'b1;
        end
        if (wr_commit) begin
          if (wr_ok) begin
            for (int k = 0; k < 4; k++) begin
              if (cm_strb[k]) regs_d[wr_idx][k*8 +: 8] = cm_data[k*8 +: 8];
            end
          end
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wstate_d  = W_RESP;
        end else if (have_aw || have_w) begin
          awready_d = !have_aw;
          wready_d  = !have_w;
          wstate_d  = W_WAIT;
        end else begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read data is taken from the current register values, so a same-cycle write is not visible.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_idx    = addr_idx(s_araddr);
    ar_hit    = addr_hit(s_araddr);
    case (rstate_q)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          rdata_d   = ar_hit ? reg_word[ar_idx] : 32'h0;
          rresp_d   = ar_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_RESP;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

`ifdef AXI_LITE_REGS_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  always_comb begin
    wr_pulse_d = '0;
    if (wr_commit && wr_ok) wr_pulse_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_pulse_q <= '0;
    else          wr_pulse_q <= wr_pulse_d;
  end

  assign wr_pulse = wr_pulse_q;
`else
  assign wr_pulse = '0;
`endif

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized bench for axi4_lite_slave_regs against an array model of the register bank.
module tb_axi4_lite_slave_regs;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] ID       = 32'hBED0_0001;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0]  s_awcache = '0, s_arcache = '0, s_wstrb = '0;
  logic [2:0]  s_awprot = '0, s_arprot = '0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [NUM_REGS*32-1:0] regs_out;
  logic [NUM_REGS-1:0]    wr_pulse;

  logic [31:0] model [NUM_REGS];
  int n_checks = 0;
  int n_pass   = 0;

  axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_BASE(BASE), .ID_VALUE(ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit addr_in_range(input logic [31:0] addr);
    longint a = longint'(addr);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + NUM_REGS * 4);
  endfunction

  function automatic int addr_to_idx(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [NUM_REGS*32-1:0] exp_vec();
    logic [NUM_REGS*32-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*32 +: 32] = (i == 0) ? ID : model[i];
    return v;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int stall);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_fire, w_fire, ok;
    int idx;
    logic [1:0]  exp_resp;
    logic [31:0] exp_pulse;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awcache = 4'($urandom); s_awprot = 3'($urandom);
    while (!(aw_done && w_done) && cyc < 30) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      tick();
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      if (aw_done != w_done) check("wait_ready", {30'b0, s_awready, s_wready}, aw_done ? 32'd1 : 32'd2);
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    idx = addr_to_idx(addr);
    ok = addr_in_range(addr) && idx != 0;
    exp_resp = ok ? OKAY : SLVERR;
    exp_pulse = 0;
    if (ok) begin
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
`ifdef AXI_LITE_REGS_WR_PULSE_EN
      exp_pulse[idx] = 1'b1;
`endif
    end
    check("bvalid_latency", s_bvalid, 1);
    check("bresp", s_bresp, exp_resp);
    check("regs_out_all", regs_out === exp_vec(), 1);
    check("wr_pulse", 32'(wr_pulse), exp_pulse);
    check("resp_ready_low", {s_awready, s_wready}, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("bvalid_hold", s_bvalid, 1);
      check("bresp_hold", s_bresp, exp_resp);
      check("stall_ready_low", {s_awready, s_wready}, 0);
      check("stall_no_commit", regs_out === exp_vec(), 1);
      check("pulse_once", 32'(wr_pulse), 0);
    end
    s_bready = 1;
    tick();
    s_bready = 0;
    check("bvalid_clear", s_bvalid, 0);
    check("pulse_clear", 32'(wr_pulse), 0);
    check("ready_after_b", {s_awready, s_wready}, 3);
    $display("WR addr=%08h data=%08h strb=%h awd=%0d wd=%0d stall=%0d resp=%0d",
             addr, data, strb, aw_dly, w_dly, stall, s_bresp);
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall);
    int cyc = 0;
    bit fire = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    if (!addr_in_range(addr)) begin
      exp_data = 0; exp_resp = SLVERR;
    end else begin
      exp_data = (addr_to_idx(addr) == 0) ? ID : model[addr_to_idx(addr)];
      exp_resp = OKAY;
    end
    s_araddr = addr; s_arcache = 4'($urandom); s_arprot = 3'($urandom);
    s_arvalid = 1;
    while (!fire && cyc < 30) begin
      fire = s_arready;
      tick();
      cyc++;
    end
    s_arvalid = 0;
    if (!fire) check("rd_handshake_timeout", 0, 1);
    check("rvalid_latency", s_rvalid, 1);
    check("rdata", s_rdata, exp_data);
    check("rresp", s_rresp, exp_resp);
    check("arready_low", s_arready, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("rvalid_hold", s_rvalid, 1);
      check("rdata_hold", s_rdata, exp_data);
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    check("rvalid_clear", s_rvalid, 0);
    check("arready_back", s_arready, 1);
    $display("RD addr=%08h data=%08h resp=%0d stall=%0d", addr, exp_data, exp_resp, stall);
  endtask

  initial begin
    logic [31:0] addr;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 0;
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_bvalid", s_bvalid, 0);
    repeat (3) tick();
    aresetn = 1;
    check("ready_before_rise", {s_awready, s_wready, s_arready}, 0);
    tick();
    check("ready_after_rise", {s_awready, s_wready, s_arready}, 7);
    check("rst_regs", regs_out === exp_vec(), 1);

    do_read(BASE + 0, 0);
    do_read(BASE + 4, 0);

    do_write(BASE + 8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_write(BASE + 8, 32'h0000_1234, 4'b0011, 0, 0, 0);
    check("slice2_literal", regs_out[95:64], 32'hDEAD_1234);
    do_read(BASE + 8, 1);

    do_write(BASE + 12, 32'h1111_2222, 4'hF, 0, 3, 0);
    do_write(BASE + 16, 32'h3333_4444, 4'hF, 3, 0, 0);
    do_write(BASE + 20, 32'h5555_6666, 4'h0, 1, 2, 0);

    do_write(BASE + 0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(BASE + NUM_REGS * 4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_read(BASE + 64, 0);
    do_read(BASE - 4, 0);

    do_write(BASE + 4, 32'hCAFE_0004, 4'hF, 0, 0, 0);
    fork
      do_write(BASE + 8, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
      begin
        tick(); tick();
        do_read(BASE + 4, 0);
      end
    join

    // Read and write of the same register handshaking on the same edge.
    fork
      do_write(BASE + 12, 32'h7777_8888, 4'hF, 0, 0, 0);
      do_read(BASE + 12, 0);
    join
    do_read(BASE + 12, 0);

    // Reset while AW is held and W has not arrived.
    s_awaddr = BASE + 4; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    #2;
    aresetn = 0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 0;
    check("midrst_readys", {s_awready, s_wready, s_arready}, 0);
    check("midrst_valids", {s_bvalid, s_rvalid}, 0);
    check("midrst_resps", {s_bresp, s_rresp}, 0);
    check("midrst_rdata", s_rdata, 0);
    check("midrst_regs", regs_out === exp_vec(), 1);
    check("midrst_pulse", 32'(wr_pulse), 0);
    tick();
    aresetn = 1;
    tick();
    check("midrst_ready_rise", {s_awready, s_wready, s_arready}, 7);
    do_write(BASE + 4, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    do_read(BASE + 4, 0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0: addr = BASE - 4 * $urandom_range(1, 4);
        1: addr = BASE + NUM_REGS * 4 + 4 * $urandom_range(0, 3);
        2: addr = BASE + $urandom_range(0, 3);
        default: addr = BASE + 4 * $urandom_range(0, NUM_REGS - 1) + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(addr, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
